// File: rtl/apb_gpio_master.sv
`default_nettype none
// ============================================================================
//  Module   : apb_gpio_master
//  Purpose  : APB master for the GPIO slave; serialises host register
//             accesses and runs an atomic interrupt read-and-clear sequence.
//  Revision : 1.0  initial release
// ============================================================================

`ifndef GPIO_RGPIO_INTS
`define GPIO_RGPIO_INTS 32'h0000_001C
`endif

module apb_gpio_master #(
    parameter logic [31:0] INTS_ADDR   = `GPIO_RGPIO_INTS,
    parameter int unsigned TIMEOUT     = 16,
    parameter int unsigned IRQ_HOLDOFF = 4
) (
    input  logic        PCLK,
    input  logic        PRESETn,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [31:0] cmd_addr,
    input  logic [31:0] cmd_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    input  logic        irq_en,
    input  logic        IRQ,
    output logic        irq_done,
    output logic [31:0] irq_ints,
    output logic        irq_err,
    output logic        PSEL,
    output logic        PENABLE,
    output logic        PWRITE,
    output logic [31:0] PADDR,
    output logic [31:0] PWDATA,
    input  logic [31:0] PRDATA,
    input  logic        PREADY
);

    localparam logic [1:0] c_ST_IDLE   = 2'd0;
    localparam logic [1:0] c_ST_SETUP  = 2'd1;
    localparam logic [1:0] c_ST_ACCESS = 2'd2;

    localparam logic [1:0] c_PH_NONE = 2'd0;
    localparam logic [1:0] c_PH_RD   = 2'd1;
    localparam logic [1:0] c_PH_WR   = 2'd2;

    localparam logic [7:0] c_TIMEOUT = 8'(TIMEOUT);
    localparam logic [3:0] c_HOLDOFF = 4'(IRQ_HOLDOFF);

    logic [1:0]  r_state;
    logic [1:0]  r_svc_phase;
    logic [7:0]  r_tcnt;
    logic [3:0]  r_holdoff;
    logic [31:0] r_ints_buf;

    logic w_svc_pending;
    logic w_expired;

    assign w_svc_pending = irq_en & IRQ & (r_holdoff == 4'd0);
    assign cmd_ready     = PRESETn & (r_state == c_ST_IDLE) & ~w_svc_pending;
    assign w_expired     = ((r_tcnt + 8'd1) == c_TIMEOUT);

    always_ff @(posedge PCLK) begin
        if (!PRESETn) begin
            r_state     <= c_ST_IDLE;
            r_svc_phase <= c_PH_NONE;
            r_tcnt      <= 8'd0;
            r_holdoff   <= 4'd0;
            r_ints_buf  <= 32'd0;
            PSEL        <= 1'b0;
            PENABLE     <= 1'b0;
            PWRITE      <= 1'b0;
            PADDR       <= 32'd0;
            PWDATA      <= 32'd0;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= 32'd0;
            rsp_err     <= 1'b0;
            irq_done    <= 1'b0;
            irq_ints    <= 32'd0;
            irq_err     <= 1'b0;
        end else begin
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            irq_done  <= 1'b0;
            irq_err   <= 1'b0;
            if (r_holdoff != 4'd0) begin
                r_holdoff <= r_holdoff - 4'd1;
            end

            case (r_state)
                c_ST_IDLE: begin
                    if (w_svc_pending) begin
                        r_state     <= c_ST_SETUP;
                        r_svc_phase <= c_PH_RD;
                        PSEL        <= 1'b1;
                        PENABLE     <= 1'b0;
                        PWRITE      <= 1'b0;
                        PADDR       <= INTS_ADDR;
                        PWDATA      <= 32'd0;
                    end else if (cmd_valid) begin
                        r_state     <= c_ST_SETUP;
                        r_svc_phase <= c_PH_NONE;
                        PSEL        <= 1'b1;
                        PENABLE     <= 1'b0;
                        PWRITE      <= cmd_write;
                        PADDR       <= cmd_addr;
                        PWDATA      <= cmd_write ? cmd_wdata : 32'd0;
                    end
                end

                c_ST_SETUP: begin
                    r_state <= c_ST_ACCESS;
                    PENABLE <= 1'b1;
                    r_tcnt  <= 8'd0;
                end

                c_ST_ACCESS: begin
                    if (PREADY) begin
                        PENABLE <= 1'b0;
                        case (r_svc_phase)
                            c_PH_NONE: begin
                                PSEL      <= 1'b0;
                                r_state   <= c_ST_IDLE;
                                rsp_valid <= 1'b1;
                                rsp_rdata <= PWRITE ? 32'd0 : PRDATA;
                            end
                            // Straight into the clear write so the host cannot slip in between.
                            c_PH_RD: begin
                                r_ints_buf  <= PRDATA;
                                r_state     <= c_ST_SETUP;
                                r_svc_phase <= c_PH_WR;
                                PWRITE      <= 1'b1;
                                PWDATA      <= 32'd0;
                            end
                            default: begin
                                PSEL        <= 1'b0;
                                r_state     <= c_ST_IDLE;
                                r_svc_phase <= c_PH_NONE;
                                irq_done    <= 1'b1;
                                irq_ints    <= r_ints_buf;
                                r_holdoff   <= c_HOLDOFF;
                            end
                        endcase
                    end else if (w_expired) begin
                        PSEL        <= 1'b0;
                        PENABLE     <= 1'b0;
                        r_state     <= c_ST_IDLE;
                        r_svc_phase <= c_PH_NONE;
                        if (r_svc_phase == c_PH_NONE) begin
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b1;
                            rsp_rdata <= 32'd0;
                        end else begin
                            irq_done  <= 1'b1;
                            irq_err   <= 1'b1;
                            irq_ints  <= 32'd0;
                            r_holdoff <= c_HOLDOFF;
                        end
                    end else begin
                        r_tcnt <= r_tcnt + 8'd1;
                    end
                end

                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_apb_gpio_master.sv
`default_nettype none
// ============================================================================
//  Module   : tb_apb_gpio_master
//  Purpose  : Directed bench for apb_gpio_master with an APB slave model and
//             a transaction-level scoreboard.
//  Revision : 1.0  initial release
// ============================================================================
module tb_apb_gpio_master;

    localparam logic [31:0] c_INTS_ADDR = 32'h0000_001C;
    localparam logic [31:0] c_OUT       = 32'h0000_0004;
    localparam logic [31:0] c_OE        = 32'h0000_0008;
    localparam logic [31:0] c_INTE      = 32'h0000_000C;
    localparam logic [31:0] c_PTRIG     = 32'h0000_0010;
    localparam logic [31:0] c_CTRL      = 32'h0000_0018;
    localparam int          c_TIMEOUT   = 16;
    localparam int          c_HOLDOFF   = 4;

    logic        PCLK = 1'b0;
    logic        PRESETn = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_write = 1'b0;
    logic [31:0] cmd_addr = '0;
    logic [31:0] cmd_wdata = '0;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        irq_en = 1'b0;
    logic        IRQ;
    logic        irq_done;
    logic [31:0] irq_ints;
    logic        irq_err;
    logic        PSEL;
    logic        PENABLE;
    logic        PWRITE;
    logic [31:0] PADDR;
    logic [31:0] PWDATA;
    logic [31:0] PRDATA;
    logic        PREADY;

    apb_gpio_master #(
        .INTS_ADDR  (c_INTS_ADDR),
        .TIMEOUT    (c_TIMEOUT),
        .IRQ_HOLDOFF(c_HOLDOFF)
    ) dut (
        .PCLK     (PCLK),
        .PRESETn  (PRESETn),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_write(cmd_write),
        .cmd_addr (cmd_addr),
        .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid),
        .rsp_rdata(rsp_rdata),
        .rsp_err  (rsp_err),
        .irq_en   (irq_en),
        .IRQ      (IRQ),
        .irq_done (irq_done),
        .irq_ints (irq_ints),
        .irq_err  (irq_err),
        .PSEL     (PSEL),
        .PENABLE  (PENABLE),
        .PWRITE   (PWRITE),
        .PADDR    (PADDR),
        .PWDATA   (PWDATA),
        .PRDATA   (PRDATA),
        .PREADY   (PREADY)
    );

    always #5 PCLK = ~PCLK;

    int cyc = 0;
    always @(posedge PCLK) cyc <= cyc + 1;

    // ---------------- APB slave model (register file + interrupt status) ----
    logic [31:0] mem [0:63];
    logic [31:0] slv_ints = '0;
    logic [31:0] pad_val = '0;
    logic        pad_set = 1'b0;
    logic        hold_low = 1'b0;
    logic        irq_force = 1'b0;
    int          wait_states = 0;
    int          wcnt = 0;

    assign PREADY = !hold_low && (wcnt == wait_states);
    assign PRDATA = (PADDR == c_INTS_ADDR) ? slv_ints : mem[PADDR[7:2]];
    assign IRQ    = (slv_ints != 32'd0) || irq_force;

    always @(posedge PCLK) begin
        if (PSEL && PENABLE && !PREADY) wcnt <= wcnt + 1;
        else                            wcnt <= 0;
        if (PSEL && PENABLE && PREADY && PWRITE) begin
            if (PADDR == c_INTS_ADDR) slv_ints <= PWDATA;
            else                      mem[PADDR[7:2]] <= PWDATA;
        end else if (pad_set) begin
            slv_ints <= pad_val;
        end
    end

    // ---------------- scoreboard ---------------------------------------------
    typedef struct { logic [31:0] addr; logic wr; logic [31:0] wdata; int len; } apb_t;
    typedef struct { logic [31:0] rdata; logic err; int len; } rsp_t;
    typedef struct { logic [31:0] ints; logic err; } irq_t;

    apb_t apb_q[$];
    rsp_t rsp_q[$];
    irq_t irq_q[$];
    int   acc_q[$];
    logic [31:0] ref_mem [0:63];

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, want, cyc);
        end
    endtask

    logic        mon_on = 1'b0;
    apb_t        cur;
    logic        in_xfer = 1'b0;
    int          acc_cnt = 0;
    int          hold_end = 0;
    int          last_done = 0, prev_done = 0, last_acc = 0, prev_acc = 0, last_lat = 0;
    logic [31:0] last_rdata = '0, last_ints = '0;
    logic        last_err = 1'b0, last_ierr = 1'b0;

    initial begin : compare
        rsp_t r;
        irq_t q;
        int   a;
        forever begin
            @(negedge PCLK);
            if (mon_on) begin
                if (!PRESETn) begin
                    check("cmd_ready_in_reset", cmd_ready, 0);
                    apb_q.delete(); rsp_q.delete(); irq_q.delete(); acc_q.delete();
                    in_xfer  = 1'b0;
                    hold_end = 0;
                end else begin
                    if (irq_done) begin
                        check("irq_expected", irq_q.size() != 0, 1);
                        if (irq_q.size() != 0) begin
                            q = irq_q.pop_front();
                            check("irq_ints", irq_ints, q.ints);
                            check("irq_err", irq_err, q.err);
                            last_ints = irq_ints; last_ierr = irq_err;
                        end
                        prev_done = last_done;
                        last_done = cyc;
                        hold_end  = cyc + c_HOLDOFF;
                    end
                    check("cmd_ready", cmd_ready,
                          !PSEL && !(irq_en && IRQ && cyc >= hold_end));
                    if (rsp_valid) begin
                        check("rsp_expected", rsp_q.size() != 0 && acc_q.size() != 0, 1);
                        if (rsp_q.size() != 0 && acc_q.size() != 0) begin
                            r = rsp_q.pop_front();
                            a = acc_q.pop_front();
                            check("rsp_rdata", rsp_rdata, r.rdata);
                            check("rsp_err", rsp_err, r.err);
                            check("rsp_latency", cyc - a, 2 + r.len);
                            last_rdata = rsp_rdata; last_err = rsp_err; last_lat = cyc - a;
                        end
                    end
                    if (cmd_valid && cmd_ready) begin
                        acc_q.push_back(cyc);
                        prev_acc = last_acc;
                        last_acc = cyc;
                    end
                    if (PSEL && !PENABLE) begin
                        if (in_xfer) check("access_len", acc_cnt, cur.len);
                        check("setup_expected", apb_q.size() != 0, 1);
                        in_xfer = 1'b0;
                        if (apb_q.size() != 0) begin
                            cur = apb_q.pop_front();
                            check("setup_paddr", PADDR, cur.addr);
                            check("setup_pwrite", PWRITE, cur.wr);
                            check("setup_pwdata", PWDATA, cur.wdata);
                            in_xfer = 1'b1;
                            acc_cnt = 0;
                        end
                    end else if (PSEL && PENABLE) begin
                        check("access_after_setup", in_xfer, 1);
                        if (in_xfer) begin
                            acc_cnt++;
                            check("paddr_stable", PADDR, cur.addr);
                            check("pwrite_stable", PWRITE, cur.wr);
                            check("pwdata_stable", PWDATA, cur.wdata);
                        end
                    end else begin
                        check("penable_idle", PENABLE, 0);
                        if (in_xfer) begin
                            check("access_len", acc_cnt, cur.len);
                            in_xfer = 1'b0;
                        end
                    end
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------------------------------
    task automatic tick(input int n);
        repeat (n) @(posedge PCLK);
        #1;
    endtask

    function automatic int access_len();
        if (hold_low) return c_TIMEOUT;
        return (wait_states + 1 < c_TIMEOUT) ? wait_states + 1 : c_TIMEOUT;
    endfunction

    task automatic expect_host(input logic wr, input logic [31:0] addr, input logic [31:0] wd);
        apb_t a;
        rsp_t r;
        a.addr = addr; a.wr = wr; a.wdata = wr ? wd : 32'd0; a.len = access_len();
        r.err = hold_low; r.len = a.len;
        r.rdata = (wr || hold_low) ? 32'd0 : ref_mem[addr[7:2]];
        if (wr && !hold_low) ref_mem[addr[7:2]] = wd;
        apb_q.push_back(a);
        rsp_q.push_back(r);
    endtask

    task automatic expect_service(input logic [31:0] ints);
        apb_t a;
        irq_t q;
        a.addr = c_INTS_ADDR; a.wr = 1'b0; a.wdata = 32'd0; a.len = access_len();
        apb_q.push_back(a);
        if (!hold_low) begin
            a.wr = 1'b1;
            apb_q.push_back(a);
        end
        q.ints = hold_low ? 32'd0 : ints;
        q.err  = hold_low;
        irq_q.push_back(q);
    endtask

    task automatic issue(input logic wr, input logic [31:0] addr, input logic [31:0] wd);
        int n = 0;
        cmd_write = wr; cmd_addr = addr; cmd_wdata = wd; cmd_valid = 1'b1;
        @(negedge PCLK);
        while (!cmd_ready && n < 200) begin
            n++;
            @(negedge PCLK);
        end
        check("accept_wait", n < 200, 1);
        @(posedge PCLK);
        #1 cmd_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((apb_q.size() != 0 || rsp_q.size() != 0 || irq_q.size() != 0 || in_xfer || PSEL)
               && n < 300) begin
            n++;
            @(negedge PCLK);
        end
        check("drain_wait", n < 300, 1);
        @(posedge PCLK);
        #1;
    endtask

    task automatic host_cmd(input logic wr, input logic [31:0] addr, input logic [31:0] wd);
        expect_host(wr, addr, wd);
        issue(wr, addr, wd);
        wait_idle();
    endtask

    task automatic pad(input logic [31:0] v);
        pad_val = v;
        pad_set = 1'b1;
        @(posedge PCLK);
        #1 pad_set = 1'b0;
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation still running at %0t, expected summary earlier", $time);
        $fatal(1);
    end

    // ---------------- directed sequence ----------------------------------------
    initial begin : stim
        int n;
        PRESETn = 1'b0;
        tick(2);
        mon_on = 1'b1;
        tick(1);
        @(negedge PCLK);
        check("rst_ctrl", {PSEL, PENABLE, PWRITE, rsp_valid, rsp_err, irq_done, irq_err}, 0);
        check("rst_data", PADDR | PWDATA | rsp_rdata | irq_ints, 0);
        @(posedge PCLK);
        #1 PRESETn = 1'b1;
        tick(2);

        // Host write then read, zero-wait slave.
        wait_states = 0;
        host_cmd(1'b1, c_OUT, 32'hAAAA_FFFF);
        check("wr_latency", last_lat, 3);
        host_cmd(1'b0, c_OUT, 32'd0);
        check("rd_data", last_rdata, 32'hAAAA_FFFF);
        check("rd_latency", last_lat, 3);
        check("rd_err", last_err, 0);

        // Two wait states.
        wait_states = 2;
        host_cmd(1'b0, c_OUT, 32'd0);
        check("ws_latency", last_lat, 5);
        wait_states = 0;

        // Back-to-back configuration writes: one transfer per three cycles.
        expect_host(1'b1, c_OE, 32'd0);
        expect_host(1'b1, c_PTRIG, 32'hFFFF_FFFF);
        issue(1'b1, c_OE, 32'd0);
        issue(1'b1, c_PTRIG, 32'hFFFF_FFFF);
        wait_idle();
        check("throughput", last_acc - prev_acc, 3);
        host_cmd(1'b1, c_INTE, 32'hFFFF_FFFF);
        host_cmd(1'b1, c_CTRL, 32'h0000_0001);

        // Interrupt service.
        irq_en = 1'b1;
        expect_service(32'hFFFF_FFFF);
        pad(32'hFFFF_FFFF);
        wait_idle();
        check("svc_ints", last_ints, 32'hFFFF_FFFF);
        check("svc_err", last_ierr, 0);
        check("ints_cleared", slv_ints, 32'd0);
        check("irq_dropped", IRQ, 0);
        tick(10);

        // IRQ held high: second sequence waits out the holdoff; IRQ/irq_en drop mid-sequence.
        expect_service(32'h0000_005A);
        expect_service(32'd0);
        irq_force = 1'b1;
        pad(32'h0000_005A);
        n = 0;
        while (irq_q.size() > 1 && n < 100) begin
            n++;
            @(negedge PCLK);
        end
        check("svc1_wait", n < 100, 1);
        tick(6);
        irq_force = 1'b0;
        irq_en    = 1'b0;
        wait_idle();
        check("holdoff_gap", last_done - prev_done, 9);
        check("svc2_ints", last_ints, 32'd0);
        tick(8);

        // Contention: command raised in the same cycle IRQ rises.
        irq_en = 1'b1;
        expect_service(32'h0000_0003);
        expect_host(1'b1, c_OUT, 32'h1234_5678);
        pad(32'h0000_0003);
        issue(1'b1, c_OUT, 32'h1234_5678);
        wait_idle();
        check("contention_accept", last_acc, last_done);
        tick(6);

        // Host timeout, then normal recovery.
        hold_low = 1'b1;
        host_cmd(1'b0, c_OUT, 32'd0);
        check("to_err", last_err, 1);
        check("to_rdata", last_rdata, 32'd0);
        check("to_latency", last_lat, 18);
        hold_low = 1'b0;
        host_cmd(1'b0, c_OUT, 32'd0);
        check("after_to_data", last_rdata, 32'h1234_5678);

        // Service timeout on the read phase; the clear write is skipped.
        hold_low = 1'b1;
        expect_service(32'h0000_0007);
        pad(32'h0000_0007);
        n = 0;
        while (irq_q.size() != 0 && n < 100) begin
            n++;
            @(negedge PCLK);
        end
        check("svc_to_wait", n < 100, 1);
        @(posedge PCLK);
        #1 irq_en = 1'b0;
        hold_low = 1'b0;
        check("svc_to_err", last_ierr, 1);
        check("svc_to_ints", last_ints, 32'd0);
        pad(32'd0);
        wait_idle();
        tick(6);

        // Reset in the middle of an ACCESS phase.
        wait_states = 3;
        expect_host(1'b0, c_OUT, 32'd0);
        issue(1'b0, c_OUT, 32'd0);
        n = 0;
        @(negedge PCLK);
        while (!PENABLE && n < 20) begin
            n++;
            @(negedge PCLK);
        end
        check("reach_access", PENABLE, 1);
        @(posedge PCLK);
        #1 PRESETn = 1'b0;
        @(posedge PCLK);
        #1 PRESETn = 1'b1;
        @(negedge PCLK);
        check("rst_mid_ctrl", {PSEL, PENABLE, PWRITE, rsp_valid, rsp_err, irq_done, irq_err}, 0);
        check("rst_mid_data", PADDR | PWDATA | rsp_rdata | irq_ints, 0);
        check("rst_mid_idle", cmd_ready, 1);
        tick(10);
        wait_states = 0;
        host_cmd(1'b0, c_OUT, 32'd0);
        check("after_rst_data", last_rdata, 32'h1234_5678);
        tick(4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/apb_gpio_master.md
# apb_gpio_master

APB master and requester arbiter that owns the bus into the GPIO APB slave (`apb_top`). It serialises host register accesses (configuration writes, status reads) and runs a built-in interrupt-service sequence: on `IRQ` it reads RGPIO_INTS, reports the value, and writes 0 back to clear it. The service sequence has priority over the host and is atomic. A per-transfer PREADY timeout guarantees forward progress.

## Interface
- `INTS_ADDR`, default `` `GPIO_RGPIO_INTS `` (from gpio_defines.sv): address of the interrupt status register.
- `TIMEOUT`, default 16: maximum ACCESS cycles to wait for PREADY; range 1..255.
- `IRQ_HOLDOFF`, default 4: cycles `IRQ` is ignored after a service clear completes; range 0..15.
- `PCLK` in 1: the single clock; all logic on rising edge.
- `PRESETn` in 1: reset, synchronous, active-low.
- `cmd_valid` in 1: host command request.
- `cmd_ready` out 1: command accepted on an edge where `cmd_valid` and `cmd_ready` are both 1.
- `cmd_write` in 1: 1 = write, 0 = read.
- `cmd_addr` in 32: target register address.
- `cmd_wdata` in 32: write data.
- `rsp_valid` out 1: one-cycle pulse when a host command completes.
- `rsp_rdata` out 32: read data; 0 for writes and errors.
- `rsp_err` out 1: the command timed out; qualified by `rsp_valid`.
- `irq_en` in 1: enables the automatic service sequence.
- `IRQ` in 1: level interrupt from the GPIO block.
- `irq_done` out 1: one-cycle pulse when the service sequence ends.
- `irq_ints` out 32: INTS value read by the service sequence; qualified by `irq_done`.
- `irq_err` out 1: the service sequence timed out; qualified by `irq_done`.
- `PSEL`, `PENABLE`, `PWRITE` out 1 each: APB master controls.
- `PADDR`, `PWDATA` out 32 each: APB address and write data.
- `PRDATA` in 32: APB read data.
- `PREADY` in 1: APB ready.

## Operation
- States:
  - IDLE
  - SETUP (`PSEL`=1, `PENABLE`=0)
  - ACCESS (`PSEL`=1, `PENABLE`=1)
- Sequence flag `svc_phase` takes values NONE, RD, WR.
- Arbitration in IDLE, evaluated each cycle:
  - Service is pending when `irq_en` & `IRQ` & holdoff counter = 0. Pending service starts a read of `INTS_ADDR` (`svc_phase`=RD).
  - Otherwise, if `cmd_valid`, the host command is accepted.
  - `cmd_ready` = (state==IDLE) & !service_pending, combinational.
- Accepting a request latches `PADDR`, `PWRITE` and `PWDATA` (reads drive `PWDATA`=0) and moves to SETUP. SETUP always moves to ACCESS on the next edge.
- ACCESS with `PREADY`=1 at an edge completes the transfer:
  - `PSEL` and `PENABLE` drop.
  - `PRDATA` is captured on reads.
  - Host transfer: `rsp_valid`=1 for the next cycle with `rsp_rdata`, and `rsp_err`=0.
  - Service RD: store `PRDATA`, then go directly to SETUP of a write of 0x0 to `INTS_ADDR` (`svc_phase`=WR). IDLE is skipped, so the host cannot interleave.
  - Service WR: pulse `irq_done` with the stored `irq_ints` and `irq_err`=0, load holdoff counter with `IRQ_HOLDOFF`, return to IDLE.
- Timeout: an 8-bit counter clears on SETUP and increments each ACCESS cycle without `PREADY`.
  - When it reaches `TIMEOUT` the transfer is abandoned: next cycle IDLE, `PSEL`/`PENABLE`=0.
  - Host transfer: `rsp_valid`=1, `rsp_err`=1, `rsp_rdata`=0.
  - Service transfer, either phase: `irq_done`=1, `irq_err`=1, `irq_ints`=0. Holdoff is loaded, and any remaining phase is skipped.
- Holdoff counter decrements each cycle while nonzero. `IRQ` falling during a sequence does not abort it.
- `irq_en` deasserted mid-sequence does not abort it; it only blocks new starts.

## Timing
- Reset (`PRESETn`=0 at an edge):
  - State IDLE, counters 0, `svc_phase` NONE.
  - `PSEL`, `PENABLE`, `PWRITE`, `rsp_valid`, `rsp_err`, `irq_done`, `irq_err` = 0.
  - `PADDR`, `PWDATA`, `rsp_rdata`, `irq_ints` = 0.
  - In-flight transfers are dropped with no response. `cmd_ready` is 0 while `PRESETn`=0.
- All outputs except `cmd_ready` are registered.
- Host transfer with zero-wait `PREADY`:
  - accept edge N
  - SETUP cycle N+1
  - ACCESS cycle N+2; completes on edge N+3
  - `rsp_valid` high during cycle N+3, with `cmd_ready`=1 in the same cycle
- Sustained host throughput is 1 transfer per 3 cycles. Each wait state adds 1 cycle.
- Service sequence with zero-wait `PREADY`:
  - SETUP/ACCESS RD, then SETUP/ACCESS WR
  - `irq_done` 4 cycles after the start edge
- Simultaneous `cmd_valid` and pending service in IDLE: service wins. The host waits with `cmd_ready`=0; its command is accepted the first IDLE cycle after the sequence.
- `PADDR`, `PWRITE` and `PWDATA` are stable from SETUP through the final ACCESS cycle.

## Test plan
- Host write OUT=0xAAAA_FFFF then read OUT, slave zero-wait. Required:
  - `rsp_valid` 3 cycles after each accept
  - read returns `rsp_rdata`=0xAAAA_FFFF, `rsp_err`=0
  - APB SETUP precedes ACCESS in both transfers
- Host read with 2 wait states. Required:
  - ACCESS lasts 3 cycles, `rsp_valid` 5 cycles after accept
  - `PADDR` stable throughout
- Interrupt service, `irq_en`=1: OE=0, PTRIG=INTE=0xFFFF_FFFF, CTRL=0b01, then drive pads 0xFFFF_FFFF. Required:
  - `IRQ`=1 triggers read of `INTS_ADDR`, then write 0x0 to it
  - `irq_done` with `irq_ints`=0xFFFF_FFFF
  - `IRQ` drops, and no second sequence starts during holdoff
- Contention: `cmd_valid` asserted on the same cycle `IRQ` rises. Required:
  - `cmd_ready`=0 until `irq_done`
  - host command issued on the APB only after the INTS clear write
- Timeout, `TIMEOUT`=16, `PREADY` held 0. Required:
  - bus released after 16 ACCESS cycles
  - `rsp_valid`=1 with `rsp_err`=1 and `rsp_rdata`=0
  - next command proceeds normally
- `PRESETn` pulsed low during ACCESS. Required:
  - all outputs 0 on the next edge
  - no `rsp_valid` for the dropped transfer
  - state IDLE
